cmp_sort_ctrl: RTL and testbench
================================

Name: cmp_sort_ctrl

Overview:
Sequencer that shares a single comparator_gt instance (32-bit signed a > b) to sort a frame of DEPTH words. The block has three phases:
- Load: accepts DEPTH signed 32-bit words over a valid/ready input stream.
- Sort: runs an in-place ascending bubble sort, one comparison per cycle.
- Drain: streams the sorted frame out over a valid/ready output with a last flag.
It sits between a producer and a consumer as the scheduler of the comparator datapath.

Parameters:
DEPTH, 8, words per frame; legal range 2..64.
IDX_W, 3, index width; must equal clog2(DEPTH).

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  producer has a word
in_ready  output  1  block accepts a word this cycle
in_data  input  32  signed input word
out_valid  output  1  out_data holds a sorted word
out_ready  input  1  consumer accepts a word
out_data  output  32  sorted word, ascending signed order
out_last  output  1  high with the final word of the frame
busy  output  1  high in SORT and DRAIN
cmp_count  output  16  number of comparisons in the most recent sort

Behaviour:
- Reset: rst_n sampled low at a clock edge forces the following, regardless of state (including mid-sort or mid-drain):
  - state = LOAD, wr_ptr = 0, rd_ptr = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, busy = 0, cmp_count = 0, out_data = 0.
  - Frame storage contents are don't-care.
- Storage: mem[0..DEPTH-1], 32-bit registers.
- Comparator: a = mem[j], b = mem[j+1]; gt is the signed result. Only this one instance is used.
- LOAD:
  - in_ready = 1.
  - Each in_valid && in_ready edge writes mem[wr_ptr] = in_data and increments wr_ptr.
  - On the DEPTH-th accept: wr_ptr wraps to 0, go to SORT next cycle, and in_ready drops in that same next cycle.
- SORT:
  - in_ready = 0; in_valid is ignored.
  - Registers: pass counter p (0..DEPTH-2) and position j (0..DEPTH-2-p). On entry p = 0, j = 0, cmp_count cleared to 0.
  - Each cycle: one comparison, and cmp_count increments.
  - If gt = 1, mem[j] and mem[j+1] swap at that edge. Equal values never swap, so the sort is stable.
  - If j = DEPTH-2-p: j returns to 0 and p increments. Otherwise j increments.
  - After the comparison at p = DEPTH-2, j = 0, go to DRAIN.
  - Sort latency is exactly DEPTH*(DEPTH-1)/2 cycles (28 at DEPTH = 8).
- DRAIN:
  - out_valid = 1 and out_data = mem[rd_ptr], both registered.
  - out_last = 1 when rd_ptr = DEPTH-1.
  - Each out_valid && out_ready edge advances rd_ptr.
  - out_data remains stable while out_ready = 0.
  - After the handshake with out_last = 1: rd_ptr = 0, go to LOAD, out_valid = 0 the next cycle, in_ready = 1 the next cycle.
- Throughput: no bubble between consecutive drain words while out_ready = 1.
- Handshake overlap: no LOAD/DRAIN overlap; a new frame is accepted only after the previous frame has fully drained.
- cmp_count holds its value from the end of SORT until the next SORT entry.
- busy = 1 exactly when state is SORT or DRAIN.

Optional Feature:
CMP_SORT_EARLY_EXIT_EN
- Defined:
  - A swap flag is cleared at the start of each pass and set on any swap.
  - At the end of a pass with no swap, go directly to DRAIN.
  - Already-sorted input finishes in DEPTH-1 comparisons, so cmp_count = 7 at DEPTH = 8.
  - Output order is identical to the non-early-exit build.
- Undefined: fixed DEPTH*(DEPTH-1)/2 comparisons for every frame; there is no swap-flag logic.

Test Plan:
1. Reset, then load 8,7,6,5,4,3,2,1 with out_ready = 1 -> busy high for 28 SORT cycles plus 8 DRAIN cycles; out_data 1..8 on consecutive cycles; out_last with 8; cmp_count = 28.
2. Signed mix -5,-6,5,-6,12381,8484,0,-1 -> output -6,-6,-5,-1,0,5,8484,12381; the first -6 out is the one loaded second (stability).
3. Already-sorted 0..7 -> cmp_count = 7 with CMP_SORT_EARLY_EXIT_EN defined, 28 without; output 0..7 in both builds.
4. Drain backpressure: out_ready pattern 1,0,0,1,0,1... -> each word is held stable while out_ready = 0; no word is lost or duplicated; out_last is asserted only on the 8th word.
5. in_valid held high through SORT and DRAIN with changing in_data -> in_ready = 0 throughout and the frame is unchanged. The next frame loads only after the out_last handshake.
6. rst_n low for one cycle at SORT cycle 10, then load 3,1,2,0,0,0,0,0 -> no partial output; state is LOAD with in_ready = 1 after reset; the new frame sorts to 0,0,0,0,0,1,2,3.

Source files
------------

// File: rtl/cmp_sort_if.sv
// Load/drain stream bundle for cmp_sort_ctrl: a valid/ready word input and a
// valid/ready sorted-word output carrying a last flag.
interface cmp_sort_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Frame sorter: loads DEPTH signed words, bubble-sorts them through one shared
// comparator_gt, then drains ascending. Define CMP_SORT_EARLY_EXIT_EN to stop after a swap-free pass.
module comparator_gt (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic               gt_o
);
  assign gt_o = a_i > b_i;
endmodule

module cmp_sort_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  cmp_sort_if.slave   s,
  output logic        busy,
  output logic [15:0] cmp_count
);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_e;

  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(DEPTH - 2);

  state_e             state_q, state_d;
  logic signed [31:0] mem_q [DEPTH];
  logic signed [31:0] mem_d [DEPTH];
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   p_q, p_d, j_q, j_d, j_nxt;
  logic [15:0]        cnt_q, cnt_d;
  logic               ov_q, ov_d, ol_q, ol_d;
  logic signed [31:0] od_q, od_d;
  logic               gt, pass_end, done;
`ifdef CMP_SORT_EARLY_EXIT_EN
  logic               swp_q, swp_d;
`endif

  assign j_nxt    = j_q + IDX_W'(1);
  assign pass_end = (j_q == LAST_P - p_q);

  comparator_gt u_cmp (.a_i(mem_q[j_q]), .b_i(mem_q[j_nxt]), .gt_o(gt));

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    p_d      = p_q;
    j_d      = j_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    ol_d     = ol_q;
    od_d     = od_q;
    done     = 1'b0;
`ifdef CMP_SORT_EARLY_EXIT_EN
    swp_d    = swp_q;
`endif
    case (state_q)
      LOAD: begin
        if (s.in_valid) begin
          mem_d[wr_ptr_q] = s.in_data;
          if (wr_ptr_q == LAST_W) begin
            wr_ptr_d = '0;
            state_d  = SORT;
            p_d      = '0;
            j_d      = '0;
            cnt_d    = '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swp_d    = 1'b0;
`endif
          end else begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
          end
        end
      end
      SORT: begin
        cnt_d = cnt_q + 16'd1;
        // strict greater-than keeps equal keys in arrival order
        if (gt) begin
          mem_d[j_q]   = mem_q[j_nxt];
          mem_d[j_nxt] = mem_q[j_q];
        end
        if (pass_end) begin
          j_d  = '0;
          p_d  = p_q + IDX_W'(1);
          done = (p_q == LAST_P);
`ifdef CMP_SORT_EARLY_EXIT_EN
          if (!(swp_q || gt)) done = 1'b1;
          swp_d = 1'b0;
`endif
        end else begin
          j_d = j_nxt;
`ifdef CMP_SORT_EARLY_EXIT_EN
          swp_d = swp_q || gt;
`endif
        end
        if (done) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
          ov_d     = 1'b1;
          ol_d     = 1'b0;
          // first word must reflect the swap landing on this same edge
          od_d     = mem_d[0];
        end
      end
      DRAIN: begin
        if (s.out_ready) begin
          if (ol_q) begin
            state_d  = LOAD;
            rd_ptr_d = '0;
            ov_d     = 1'b0;
            ol_d     = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + IDX_W'(1);
            od_d     = mem_q[rd_ptr_d];
            ol_d     = (rd_ptr_d == LAST_W);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      p_q      <= '0;
      j_q      <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      ol_q     <= 1'b0;
      od_q     <= '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
      swp_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      p_q      <= p_d;
      j_q      <= j_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      ol_q     <= ol_d;
      od_q     <= od_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
      swp_q    <= swp_d;
`endif
    end
  end

  // frame storage needs no reset; contents are rewritten by every load
  always_ff @(posedge clk) mem_q <= mem_d;

  assign s.in_ready  = (state_q == LOAD);
  assign s.out_valid = ov_q;
  assign s.out_data  = od_q;
  assign s.out_last  = ol_q;
  assign busy        = (state_q != LOAD);
  assign cmp_count   = cnt_q;
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl: reversed, signed-mix, presorted,
// backpressured, in_valid-held and mid-sort-reset frames.
module tb_cmp_sort_ctrl;
  logic        clk, rst_n, busy;
  logic [15:0] cmp_count;
  cmp_sort_if  ifc();

  cmp_sort_ctrl #(.DEPTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .s(ifc), .busy(busy), .cmp_count(cmp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  logic signed [31:0] vin [8];
  logic signed [31:0] vexp [8];
  logic signed [31:0] got [8];
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", tag, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  32'(ifc.in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(ifc.out_valid), 32'd0);
    chk({tag, ".out_last"},  32'(ifc.out_last),  32'd0);
    chk({tag, ".busy"},      32'(busy),          32'd0);
  endtask

  task automatic load(input string nm, input bit hold);
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!ifc.in_ready) bad++;
      ifc.in_valid = 1'b1;
      ifc.in_data  = vin[i];
    end
    @(negedge clk);
    ifc.in_valid = hold;
    ifc.in_data  = $urandom;
    chk({nm, ".load_ready"}, 32'(bad), 32'd0);
  endtask

  task automatic run_frame(input string nm, input int exp_cmp, input bit bp, input bit hold);
    int sc = 0, n = 0, cyc = 0, stab = 0, rdy_bad = 0, busy_bad = 0;
    logic [7:0] lastm = '0;
    logic signed [31:0] prev = '0;
    bit pend = 1'b0, r;
    load(nm, hold);
    while (busy && !ifc.out_valid && sc < 3000) begin
      if (ifc.in_ready) rdy_bad++;
      if (hold) ifc.in_data = $urandom;
      sc++;
      @(negedge clk);
    end
    chk({nm, ".sort_cycles"}, 32'(sc), 32'(exp_cmp));
    while (n < 8 && cyc < 200) begin
      if (!ifc.out_valid || !busy) busy_bad++;
      if (ifc.in_ready) rdy_bad++;
      if (pend && ifc.out_data !== prev) stab++;
      if (ifc.out_last) lastm[n[2:0]] = 1'b1;
      r = bp ? pat[cyc % 6] : 1'b1;
      ifc.out_ready = r;
      if (hold) ifc.in_data = $urandom;
      if (ifc.out_valid && r) begin
        got[n[2:0]] = ifc.out_data;
        n++;
        pend = 1'b0;
      end else begin
        pend = ifc.out_valid;
        prev = ifc.out_data;
      end
      @(negedge clk);
      cyc++;
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    chk({nm, ".words"}, 32'(n), 32'd8);
    if (!bp) chk({nm, ".drain_cycles"}, 32'(cyc), 32'd8);
    chk({nm, ".drain_busy_valid"}, 32'(busy_bad), 32'd0);
    chk({nm, ".stable"}, 32'(stab), 32'd0);
    chk({nm, ".last_mask"}, 32'(lastm), 32'h80);
    chk({nm, ".in_ready_low"}, 32'(rdy_bad), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("%s.word%0d", nm, i), got[i], vexp[i]);
    chk({nm, ".cmp_count"}, 32'(cmp_count), 32'(exp_cmp));
    chk_idle({nm, ".post"});
  endtask

  initial begin
    int ee_sorted, ee_mix, ee_big, ee_r6, bad_ov;
`ifdef CMP_SORT_EARLY_EXIT_EN
    ee_sorted = 7;  ee_mix = 25; ee_big = 25; ee_r6 = 22;
`else
    ee_sorted = 28; ee_mix = 28; ee_big = 28; ee_r6 = 28;
`endif
    rst_n = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_idle("reset");
    chk("reset.cmp_count", 32'(cmp_count), 32'd0);
    chk("reset.out_data", ifc.out_data, 32'd0);

    vin = '{8, 7, 6, 5, 4, 3, 2, 1};
    vexp = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame("rev", 28, 1'b0, 1'b0);

    vin = '{-5, -6, 5, -6, 12381, 8484, 0, -1};
    vexp = '{-6, -6, -5, -1, 0, 5, 8484, 12381};
    run_frame("mix", ee_mix, 1'b0, 1'b0);

    vin = '{0, 1, 2, 3, 4, 5, 6, 7};
    vexp = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_frame("sorted", ee_sorted, 1'b0, 1'b0);

    vin = '{8, 7, 6, 5, 4, 3, 2, 1};
    vexp = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_frame("bp", 28, 1'b1, 1'b0);

    vin = '{100, -100, 7, 7, 32'sh80000000, 32'sh7fffffff, 0, 1};
    vexp = '{32'sh80000000, -100, 0, 1, 7, 7, 100, 32'sh7fffffff};
    run_frame("hold", ee_big, 1'b0, 1'b1);

    vin = '{0, 1, 2, 3, 4, 5, 6, 7};
    vexp = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_frame("after_hold", ee_sorted, 1'b0, 1'b0);

    // abort a sort partway through with a one-cycle reset
    vin = '{9, 8, 7, 6, 5, 4, 3, 2};
    load("abort", 1'b0);
    ifc.out_ready = 1'b1;
    bad_ov = 0;
    repeat (10) begin
      if (ifc.out_valid) bad_ov++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if (ifc.out_valid) bad_ov++;
    ifc.out_ready = 1'b0;
    chk("abort.no_output", 32'(bad_ov), 32'd0);
    chk_idle("abort.reset");
    chk("abort.cmp_count", 32'(cmp_count), 32'd0);
    chk("abort.out_data", ifc.out_data, 32'd0);

    vin = '{3, 1, 2, 0, 0, 0, 0, 0};
    vexp = '{0, 0, 0, 0, 0, 1, 2, 3};
    run_frame("r6", ee_r6, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", nerr);
    $fatal(1);
  end
endmodule
